sha1_msg_schedule: RTL



---
 rtl/sha1_msg_schedule.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sha1_msg_schedule.sv
// sha1_msg_schedule: SHA-1 message schedule and round sequencer.
// Loads one 512-bit padded block and emits W0..W79 with the matching round
// index, one word per cycle. The downstream stage can hold the sequence
// with w_stall.
// Optional feature: define SHA1_SCHED_ABORT_EN to add an 'abort' input
// that drops the block in progress and returns the stage to idle.
module sha1_msg_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         w_stall,
`ifdef SHA1_SCHED_ABORT_EN
  input  logic         abort,
`endif
  output logic         w_valid,
  output logic [31:0]  w,
  output logic [6:0]   round,
  output logic         last
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_buf [16];
  logic [6:0]  r_round;
  logic [6:0]  w_round_nxt;
  logic        r_ready;
  logic        r_wvalid;
  logic        r_last;
  logic        w_load;
  logic        w_shift;
  logic        w_abort;
  logic [31:0] w_new;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

`ifdef SHA1_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // The buffer always holds W[t..t+15]; the next word uses taps t+13, t+8, t+2, t.
  assign w_new = rotl1(r_buf[13] ^ r_buf[8] ^ r_buf[2] ^ r_buf[0]);

  // Next-state and round sequencing; abort beats both stall and the final advance.
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (blk_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
          w_round_nxt = 7'd0;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = 7'd0;
        end else if (!w_stall) begin
          w_shift = 1'b1;
          if (r_round == 7'd79) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = 7'd0;
          end else begin
            w_round_nxt = r_round + 7'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = 7'd0;
      end
    endcase
  end

  // State, round and output flags are registered so no input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_round  <= 7'd0;
      r_ready  <= 1'b1;
      r_wvalid <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_round  <= w_round_nxt;
      r_ready  <= (w_state_nxt == S_IDLE);
      r_wvalid <= (w_state_nxt == S_RUN);
      r_last   <= (w_state_nxt == S_RUN) && (w_round_nxt == 7'd79);
    end
  end

  // 16-word schedule buffer: parallel load on accept, shift-and-append on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= 32'd0;
      end
    end else if (w_load) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= blk_data[511 - 32*i -: 32];
      end
    end else if (w_shift) begin
      for (int i = 0; i < 15; i++) begin
        r_buf[i] <= r_buf[i+1];
      end
      r_buf[15] <= w_new;
    end
  end

  assign blk_ready = r_ready;
  assign w_valid   = r_wvalid;
  assign w         = r_buf[0];
  assign round     = r_round;
  assign last      = r_last;

endmodule
